// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with an integrated {HI, LO} result register.
// Signed operations run on operand magnitudes; the signs are restored in the
// FIX state. Multiply is shift-add and divide is restoring shift-subtract.
// Each iteration handles one bit.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     opr1,
    input  logic [WIDTH-1:0]     opr2,
    input  logic [1:0]           write_opt,
    input  logic [WIDTH-1:0]     write_data,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nxt;
    logic [1:0]           op_q;
    logic                 sign1_q, sign2_q, div0_q;
    logic [WIDTH-1:0]     opr1_q;     // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0]     opnd_q;     // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q;      // {partial product} or {remainder, dividend/quotient}
    logic [CW-1:0]        cnt_q;

    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   acc_mul, acc_div, fix_mul, fix_val;
    logic [WIDTH-1:0]     fix_quo, fix_rem;

    assign busy  = (state != IDLE);
    assign ready = (state == IDLE) && !start;

    // Operand magnitudes, plus a single shift-add or shift-subtract step on the accumulator.
    always_comb begin
        abs1 = (op[0] && opr1[WIDTH-1]) ? -opr1 : opr1;
        abs2 = (op[0] && opr2[WIDTH-1]) ? -opr2 : opr2;

        // Multiply: add the multiplicand into HI when the LSB of the multiplier is set, then shift right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: shift in the next dividend bit. Subtract the divisor only if it fits.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_div   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        // Restore the signs. The most-negative / -1 case needs no special handling here.
        fix_mul = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        fix_quo = (sign1_q ^ sign2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_rem = sign1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (!op_q[1])
            fix_val = fix_mul;
        else if (div0_q)
            fix_val = {opr1_q, {WIDTH{1'b1}}};
        else
            fix_val = {fix_rem, fix_quo};
    end

    // Next-state logic. A new start always restarts the calculation, even while busy.
    always_comb begin
        // NOTE: assign a default before the case statement. Without it, any path that leaves state_nxt unassigned infers a latch.
        state_nxt = state;
        if (start) begin
            state_nxt = CALC;
        end else begin
            case (state)
                CALC:    if (cnt_q == CW'(WIDTH - 1)) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: use non-blocking (<=) assignments in clocked blocks so every register samples values from before the edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: load the operands on start, then run one iteration per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            div0_q  <= 1'b0;
            opr1_q  <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            op_q    <= op;
            sign1_q <= op[0] & opr1[WIDTH-1];
            sign2_q <= op[0] & opr2[WIDTH-1];
            div0_q  <= (opr2 == '0);
            opr1_q  <= opr1;
            opnd_q  <= op[1] ? abs2 : abs1;
            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? abs1 : abs2)};
            cnt_q   <= '0;
        end else if (state == CALC) begin
            acc_q   <= op_q[1] ? acc_div : acc_mul;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // HI/LO register: FIX loads the computed value, and a direct write overrides the half it targets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else begin
            if (state == FIX && !start)
                result <= fix_val;
            if (write_opt == 2'b01)
                result[WIDTH-1:0] <= write_data;
            else if (write_opt == 2'b10)
                result[2*WIDTH-1:WIDTH] <= write_data;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. It uses a 32-bit instance and an 8-bit instance.
// Expected results come from plain signed and unsigned arithmetic.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        start;
    logic [1:0]  op;
    logic [31:0] opr1, opr2;
    logic [1:0]  write_opt;
    logic [31:0] write_data;
    logic [63:0] result;
    logic        busy, ready;

    // 8-bit instance
    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  opr1_8, opr2_8;
    logic [1:0]  write_opt8;
    logic [7:0]  write_data8;
    logic [15:0] result8;
    logic        busy8, ready8;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
        .write_opt(write_opt), .write_data(write_data),
        .result(result), .busy(busy), .ready(ready)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .opr1(opr1_8), .opr2(opr2_8),
        .write_opt(write_opt8), .write_data(write_data8),
        .result(result8), .busy(busy8), .ready(ready8)
    );

    // Reference result {HI, LO} for a w-bit operation, computed with 64-bit arithmetic.
    function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] lo_mask, full_mask, res;
        longint      sa, sb, q, r;
        lo_mask   = (64'd1 << w) - 64'd1;
        full_mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        sa = longint'(a);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        sb = longint'(b);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        case (o)
            2'b00: res = a * b;
            2'b01: res = 64'(sa * sb);
            default: begin
                if (b == 64'd0) begin
                    res = (a << w) | lo_mask;
                end else if (o == 2'b10) begin
                    res = ((a % b) << w) | (a / b);
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = ((64'(r) & lo_mask) << w) | (64'(q) & lo_mask);
                end
            end
        endcase
        return res & full_mask;
    endfunction

    // Pulse start for one cycle. Returns at the negedge after the sampling edge, with garbage on the operand inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; opr1 = a; opr2 = b;
        #1;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_drop: got %b want 0", ready);
        end
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); opr1 = $urandom; opr2 = $urandom;
    endtask

    // Count the busy cycles until the unit goes idle (bounded), and note any early change to the result.
    task automatic wait_idle(input logic [63:0] hold_val, output int cyc, output bit held);
        cyc  = 0;
        held = 1'b1;
        while (busy === 1'b1 && cyc < 200) begin
            if (result !== hold_val) held = 1'b0;
            cyc++;
            @(negedge clk);
        end
    endtask

    // Run one 32-bit operation and check latency, hold behaviour, ready and the result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prev, exp;
        int cyc;
        bit held;
        prev = result;
        exp  = model(32, o, {32'd0, a}, {32'd0, b});
        issue(o, a, b);
        wait_idle(prev, cyc, held);
        n_cmp++;
        if (cyc !== 33) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want 33", name, cyc);
        end
        n_cmp++;
        if (!held) begin
            n_bad++;
            $display("FAIL %s hold: result changed before completion (was %h)", name, prev);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready: got %b want 1", name, ready);
        end
        n_cmp++;
        if (result !== exp) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, result, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (result !== 64'd0 || busy !== 1'b0 || result8 !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got result=%h busy=%b result8=%h want 0/0/0", result, busy, result8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_multu_max();
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++;
        if (result !== 64'hFFFF_FFFE_0000_0001) begin
            n_bad++;
            $display("FAIL multu_max_const: got %h want fffffffe00000001", result);
        end
    endtask

    task automatic test_signed();
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
        n_cmp++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_bad++;
            $display("FAIL mult_neg_const: got %h want ffffffffffffffeb", result);
        end
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        n_cmp++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_neg_const: got %h want fffffffffffffffd", result);
        end
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        n_cmp++;
        if (result !== {32'd2, 32'd14}) begin
            n_bad++;
            $display("FAIL divu_100_7_const: got %h want 000000020000000e", result);
        end
    endtask

    task automatic test_div_special();
        run_op("divu_zero", 2'b10, 32'h0000_1234, 32'd0);
        n_cmp++;
        if (result !== 64'h0000_1234_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL divu_zero_const: got %h want 00001234ffffffff", result);
        end
        run_op("div_zero_neg", 2'b11, 32'h8000_0005, 32'd0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++;
        if (result !== 64'h0000_0000_8000_0000) begin
            n_bad++;
            $display("FAIL div_ovf_const: got %h want 0000000080000000", result);
        end
    endtask

    task automatic test_direct_write();
        int cyc;
        bit held;
        @(negedge clk);
        write_opt = 2'b01; write_data = 32'hAAAA_5555;
        @(negedge clk);
        write_opt = 2'b10; write_data = 32'h1234_5678;
        @(negedge clk);
        write_opt = 2'b11; write_data = 32'hFFFF_0000;
        @(negedge clk);
        write_opt = 2'b00;
        n_cmp++;
        if (result !== 64'h1234_5678_AAAA_5555 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL direct_idle: got %h busy=%b want 12345678aaaa5555 busy=0", result, busy);
        end
        // Write LO while busy: it is visible at once, then overwritten by FIX.
        issue(2'b00, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        write_opt = 2'b01; write_data = 32'h0000_DEAD;
        @(negedge clk);
        write_opt = 2'b00;
        n_cmp++;
        if (result !== 64'h1234_5678_0000_DEAD) begin
            n_bad++;
            $display("FAIL direct_busy_lo: got %h want 123456780000dead", result);
        end
        wait_idle(result, cyc, held);
        n_cmp++;
        if (result !== 64'd6) begin
            n_bad++;
            $display("FAIL direct_busy_final: got %h want 0000000000000006", result);
        end
        // Write HI during the FIX cycle: the write wins HI, and LO takes the product.
        issue(2'b00, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fix_cycle_busy: got %b want 1", busy);
        end
        write_opt = 2'b10; write_data = 32'hCAFE_F00D;
        @(negedge clk);
        write_opt = 2'b00;
        n_cmp++;
        if (result !== 64'hCAFE_F00D_0000_0006 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fix_write_hi: got %h busy=%b want cafef00d00000006 busy=0", result, busy);
        end
    endtask

    task automatic test_abort();
        logic [63:0] prev;
        int cyc;
        bit held;
        prev = result;
        issue(2'b00, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        issue(2'b00, 32'd6, 32'd6);
        wait_idle(prev, cyc, held);
        n_cmp++;
        if (!held) begin
            n_bad++;
            $display("FAIL abort_hold: result changed during aborted op (was %h)", prev);
        end
        n_cmp++;
        if (cyc !== 33) begin
            n_bad++;
            $display("FAIL abort_latency: got %0d want 33", cyc);
        end
        n_cmp++;
        if (result !== 64'd36) begin
            n_bad++;
            $display("FAIL abort_result: got %h want 0000000000000024", result);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(2'b10, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (result !== 64'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_op: got result=%h busy=%b want 0/0", result, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 2'b10, 32'd1000, 32'd7);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case (i % 6)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("random", o, a, b);
        end
    endtask

    task automatic test_width8();
        logic [1:0]  o;
        logic [7:0]  a, b;
        logic [63:0] exp;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin o = 2'b01; a = 8'h80; b = 8'h80; end
                1: begin o = 2'b11; a = 8'h80; b = 8'hFF; end
                2: begin o = 2'b11; a = 8'hF3; b = 8'h00; end
                default: begin o = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom); end
            endcase
            exp = model(8, o, {56'd0, a}, {56'd0, b});
            @(negedge clk);
            start8 = 1'b1; op8 = o; opr1_8 = a; opr2_8 = b;
            @(negedge clk);
            start8 = 1'b0; op8 = 2'($urandom); opr1_8 = 8'($urandom); opr2_8 = 8'($urandom);
            cyc = 0;
            while (busy8 === 1'b1 && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            n_cmp++;
            if (cyc !== 9 || ready8 !== 1'b1) begin
                n_bad++;
                $display("FAIL w8_latency[%0d]: got %0d ready=%b want 9 ready=1", i, cyc, ready8);
            end
            n_cmp++;
            if (result8 !== exp[15:0]) begin
                n_bad++;
                $display("FAIL w8_result[%0d]: got %h want %h", i, result8, exp[15:0]);
            end
            if (i == 0) begin
                n_cmp++;
                if (result8 !== 16'h4000) begin
                    n_bad++;
                    $display("FAIL w8_mult_const: got %h want 4000", result8);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; op = '0; opr1 = '0; opr2 = '0; write_opt = '0; write_data = '0;
        start8 = 1'b0; op8 = '0; opr1_8 = '0; opr2_8 = '0; write_opt8 = '0; write_data8 = '0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_special();
        test_direct_write();
        test_abort();
        test_reset_mid_op();
        test_back_to_back();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
